port_rx_sink: RTL

PORT_RX_SINK -- requirements
Module: port_rx_sink

---
 rtl/packet_pkg.sv | 49 ++++
 rtl/rx_cap_fifo.sv | 73 +++++++
 rtl/port_rx_sink.sv | 117 +++++++++++
 3 files changed

// File: rtl/packet_pkg.sv
// Shared packet encodings, capture-record layout and field widths for the switch
// output sinks.
package packet_pkg;

    localparam int unsigned NUM_PORTS = 4;
    localparam int unsigned PORT_W    = 4;
    localparam int unsigned TYPE_W    = 2;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned CNT_W     = 16;
    localparam int unsigned REC_W     = TYPE_W + 2 * PORT_W + DATA_W;

    typedef enum logic [TYPE_W-1:0] {
        PKT_SDATA   = 2'd0,
        PKT_MDATA   = 2'd1,
        PKT_BDATA   = 2'd2,
        PKT_ILLEGAL = 2'd3
    } pkt_type_e;

    // 18-bit capture record, MSB first: {type, source, target, data}
    typedef struct packed {
        logic [TYPE_W-1:0] ptype;
        logic [PORT_W-1:0] src;
        logic [PORT_W-1:0] tgt;
        logic [DATA_W-1:0] data;
    } cap_rec_t;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_CAPTURE = 1'b1
    } cap_state_e;

    function automatic logic is_onehot(input logic [PORT_W-1:0] v);
        return (v != '0) && ((v & (v - PORT_W'(1))) == '0);
    endfunction

    function automatic logic [1:0] onehot_idx(input logic [PORT_W-1:0] v);
        logic [1:0] idx;
        idx = '0;
        for (int i = 0; i < int'(PORT_W); i++) begin
            if (v[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/rx_cap_fifo.sv
// First-word fall-through capture buffer; a push into a full buffer succeeds only
// when a pop happens in the same cycle.
module rx_cap_fifo
    import packet_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   wr_en,
    input  cap_rec_t               wr_rec,
    input  logic                   rd_en,
    output logic                   rd_valid,
    output cap_rec_t               rd_rec,
    output logic [$clog2(DEPTH):0] level,
    output logic                   drop_c
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    cap_rec_t      mem_q [DEPTH];

    logic empty, full, do_pop, do_push;

    assign empty   = (level_q == '0);
    assign full    = (level_q == LW'(DEPTH));
    assign do_pop  = rd_en && !empty && !flush;
    assign do_push = wr_en && !flush && (!full || do_pop);
    assign drop_c  = wr_en && !flush && full && !do_pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (do_push && !do_pop)      level_d = level_q + LW'(1);
            else if (!do_push && do_pop) level_d = level_q - LW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: it is only visible through a non-empty level.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_rec;
    end

    assign rd_valid = !empty;
    assign rd_rec   = empty ? '0 : mem_q[rd_ptr_q];
    assign level    = level_q;

endmodule

// File: rtl/port_rx_sink.sv
// Terminates one switch output port: classifies samples, keeps saturating
// per-source/total/error counters and captures good packets while armed.
module port_rx_sink
    import packet_pkg::*;
#(
    parameter int unsigned PORT_ID   = 0,
    parameter int unsigned CAP_DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       valid_out,
    input  logic [3:0]                 source_out,
    input  logic [3:0]                 target_out,
    input  logic [1:0]                 pkt_type,
    input  logic [7:0]                 data_out,
    input  logic                       arm,
    input  logic                       stop,
    input  logic                       clear,
    input  logic                       rd_en,
    output logic                       rd_valid,
    output logic [17:0]                rd_data,
    input  logic [1:0]                 cnt_sel,
    output logic [15:0]                cnt_out,
    output logic [15:0]                total_cnt,
    output logic [15:0]                err_cnt,
    output logic                       overflow,
    output logic                       capturing,
    output logic [$clog2(CAP_DEPTH):0] level
);

    localparam logic [1:0] PID = 2'(PORT_ID);

    cap_state_e                          state_q, state_d;
    logic [CNT_W-1:0]                    total_q, total_d;
    logic [CNT_W-1:0]                    err_q, err_d;
    logic [NUM_PORTS-1:0][CNT_W-1:0]     src_q, src_d;
    logic                                ovf_q, ovf_d;

    logic       good, bad, cap_wr, drop;
    logic [1:0] src_idx;
    cap_rec_t   wr_rec, rd_rec;

    assign good    = valid_out && target_out[PID] && is_onehot(source_out)
                     && (pkt_type != PKT_ILLEGAL);
    assign bad     = valid_out && !good;
    assign src_idx = onehot_idx(source_out);
    assign cap_wr  = good && (state_q == ST_CAPTURE);

    assign wr_rec = '{ptype: pkt_type, src: source_out, tgt: target_out, data: data_out};

    rx_cap_fifo #(
        .DEPTH (CAP_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (clear),
        .wr_en    (cap_wr),
        .wr_rec   (wr_rec),
        .rd_en    (rd_en),
        .rd_valid (rd_valid),
        .rd_rec   (rd_rec),
        .level    (level),
        .drop_c   (drop)
    );

    // Next state for FSM and counters; clear overrides every other event.
    always_comb begin
        state_d = state_q;
        total_d = total_q;
        err_d   = err_q;
        src_d   = src_q;
        ovf_d   = ovf_q;
        if (clear) begin
            state_d = ST_IDLE;
            total_d = '0;
            err_d   = '0;
            src_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE:    if (arm && !stop) state_d = ST_CAPTURE;
                ST_CAPTURE: if (stop && !arm) state_d = ST_IDLE;
                default:    state_d = ST_IDLE;
            endcase
            if (good) begin
                total_d        = sat_inc(total_q);
                src_d[src_idx] = sat_inc(src_q[src_idx]);
            end
            if (bad)  err_d = sat_inc(err_q);
            if (drop) ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            total_q <= '0;
            err_q   <= '0;
            src_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            total_q <= total_d;
            err_q   <= err_d;
            src_q   <= src_d;
            ovf_q   <= ovf_d;
        end
    end

    assign cnt_out   = src_q[cnt_sel];
    assign total_cnt = total_q;
    assign err_cnt   = err_q;
    assign overflow  = ovf_q;
    assign capturing = (state_q == ST_CAPTURE);
    assign rd_data   = rd_rec;

endmodule
